uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter DWL, default 8, data word length in bits (5..9).
REQ-002 SHALL have parameter CLK_DIV, default 868, CLK cycles per bit (>=8).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits transmitted (1 or 2); receiver checks only the first.
REQ-004 SHALL have parameter RX_FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-005 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd; used only under UART_PARITY_EN.
REQ-006 SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Rx  in  1  serial input, asynchronous, idles high.
- Tx  out  1  serial output, idles high.
- tx_data  in  DWL  word to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  transmitter can accept a word.
- rx_data  out  DWL  FIFO head word.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops head.
- rx_overrun  out  1  one-cycle pulse: received word dropped, FIFO full.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_parity_err  out  1  one-cycle pulse: parity mismatch.

Function
REQ-007 Frame SHALL be: start (0), DWL data bits LSB first, [parity], STOP_BITS stop bits (1); each bit lasts exactly CLK_DIV cycles.
REQ-008 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when parity is compiled out.
REQ-009 tx_ready SHALL be high only in IDLE; a transfer occurs on a CLK edge with tx_valid && tx_ready, the word is latched, and Tx goes low on that same edge (START).
REQ-010 Back-to-back: tx_ready SHALL rise on the cycle after the last stop-bit cycle, so a word held on tx_valid starts with zero idle gap.
REQ-011 Tx SHALL be a registered output, glitch-free.
REQ-012 Rx SHALL pass through a 2-flop synchroniser; all RX decisions use the synchronised value.
REQ-013 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE -> START on a synchronised high-to-low transition.
REQ-014 START SHALL resample at CLK_DIV/2 cycles; if high (false start) SHALL return to IDLE with no output; else each subsequent bit SHALL be sampled every CLK_DIV cycles (mid-bit).
REQ-015 Stop sampled low SHALL pulse rx_frame_err, discard the word, and return to IDLE only after Rx is sampled high.
REQ-016 A valid word SHALL be pushed into the FIFO at the stop-bit sample cycle; rx_valid rises on the next cycle.
REQ-017 FIFO SHALL be first-word-fall-through: rx_data = head whenever rx_valid = 1; pop on rx_valid && rx_ready.
REQ-018 Push when full without simultaneous pop SHALL drop the new word and pulse rx_overrun; FIFO contents are unchanged.
REQ-019 Push and pop in the same cycle when full SHALL accept both; occupancy is unchanged.
REQ-020 rx_ready while empty SHALL have no effect; FIFO pointers SHALL wrap modulo RX_FIFO_DEPTH.
REQ-021 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-022 RST low SHALL immediately, without CLK, set: Tx = 1, tx_ready = 0, rx_valid = 0, rx_data = 0, all error pulses = 0, both FSMs = IDLE, FIFO empty, bit counters = 0.
REQ-023 Mid-frame reset SHALL abort both frames; a partial RX word SHALL NOT be stored.
REQ-024 tx_ready SHALL rise on the first CLK edge after RST is released.

Configuration
REQ-025 Macro UART_PARITY_EN defined: one parity bit SHALL follow the data bits (even if PARITY_ODD = 0, odd if 1). RX mismatch SHALL pulse rx_parity_err and discard the word.
REQ-026 UART_PARITY_EN undefined: no parity bit SHALL be sent or expected, and rx_parity_err SHALL be tied to 0.

Verification
REQ-027 DWL = 8, CLK_DIV = 16, no parity: send 0xA5 -> Tx = 0,1,0,1,0,0,1,0,1,1, 16 cycles each; tx_ready low for 160 cycles.
REQ-028 Tx looped to Rx, send 0x3C, 0xFF, 0x00 back-to-back -> FIFO yields 0x3C, 0xFF, 0x00 in order; no error pulses.
REQ-029 RX_FIFO_DEPTH = 4, rx_ready = 0, receive 5 words -> first 4 kept, 5th dropped with one rx_overrun pulse; drain returns words 1..4.
REQ-030 Rx low for 5 cycles, then high -> false start, no push, no error; a frame with stop = 0 -> one rx_frame_err pulse, FIFO unchanged.
REQ-031 UART_PARITY_EN, PARITY_ODD = 0: frame 0x01 with parity bit 0 -> rx_parity_err pulse; with parity bit 1 -> 0x01 stored.
REQ-032 RST low during TX bit 4 and RX bit 4 -> Tx = 1 at once; rx_valid stays 0; next frame after release is sent and received correctly.

Source files
------------

// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core : full-duplex UART transmitter + receiver with a receive FIFO.
//
// Frame: start bit (0), DWL data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit lasts CLK_DIV cycles of CLK.
//
// Optional feature: define UART_PARITY_EN to add one parity bit per frame
// (even when PARITY_ODD = 0, odd when PARITY_ODD = 1). Without the macro no
// parity bit is sent or expected and rx_parity_err is constant 0.
//
// Ports
//   CLK            sole clock, rising edge
//   RST            asynchronous active-low reset
//   Rx             serial input (asynchronous, idles high)
//   Tx             serial output (registered, idles high)
//   tx_data        word to transmit
//   tx_valid       tx_data is offered
//   tx_ready       transmitter idle and able to take a word
//   rx_data        FIFO head word (0 while the FIFO is empty)
//   rx_valid       FIFO not empty
//   rx_ready       consumer pops the head word
//   rx_overrun     1-cycle pulse: received word dropped, FIFO full
//   rx_frame_err   1-cycle pulse: stop bit sampled low
//   rx_parity_err  1-cycle pulse: parity mismatch
//   dbg_state      {tx_state, rx_state} for checkers and waveform viewing
//
// Handshakes: a word moves on a rising CLK edge where both valid and ready
// are high; valid may not depend on ready, and the offered data must be held
// stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module uart_core #(
    parameter int DWL           = 8,
    parameter int CLK_DIV       = 868,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 8,
    parameter int PARITY_ODD    = 0
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           Rx,
    output logic           Tx,
    input  logic [DWL-1:0] tx_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output logic [DWL-1:0] rx_data,
    output logic           rx_valid,
    input  logic           rx_ready,
    output logic           rx_overrun,
    output logic           rx_frame_err,
    output logic           rx_parity_err,
    output logic [5:0]     dbg_state
);

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam bit PAR_ODD = (PARITY_ODD != 0);
    localparam int CNT_W   = $clog2(CLK_DIV * STOP_BITS);
    localparam int BIT_W   = $clog2(DWL);
    localparam int PTR_W   = $clog2(RX_FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(CLK_DIV * STOP_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DWL - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(RX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    state_t           tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0] tx_bit, tx_bit_n;
    logic [DWL-1:0]   tx_shift, tx_shift_n;
    logic             tx_par, tx_par_n;
    logic             tx_line_n;
    logic             tx_armed;

    // tx_armed holds tx_ready low during reset and for the first edge after it.
    assign tx_ready = tx_armed && (tx_state == S_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_line_n  = Tx;
        unique case (tx_state)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    tx_state_n = S_START;
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_data;
                    tx_par_n   = (^tx_data) ^ PAR_ODD;
                    tx_line_n  = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt == BIT_END) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n = '0;
                    if (tx_bit == LAST_BIT) begin
                        if (PAR_EN) begin
                            tx_state_n = S_PARITY;
                            tx_line_n  = tx_par;
                        end else begin
                            tx_state_n = S_STOP;
                            tx_line_n  = 1'b1;
                        end
                    end else begin
                        tx_bit_n   = tx_bit + 1'b1;
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (tx_cnt == BIT_END) begin
                    tx_state_n = S_STOP;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // All stop bits are timed as one long high period.
                if (tx_cnt == STOP_END) begin
                    tx_state_n = S_IDLE;
                    tx_cnt_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_state_n = S_IDLE;
                tx_cnt_n   = '0;
                tx_line_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            Tx       <= 1'b1;
            tx_armed <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            Tx       <= tx_line_n;
            tx_armed <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver
    // -----------------------------------------------------------------------
    logic             rx_meta, rx_sync, rx_prev;
    state_t           rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [BIT_W-1:0] rx_bit, rx_bit_n;
    logic [DWL-1:0]   rx_shift, rx_shift_n;
    logic             rx_par_bad, rx_par_bad_n;
    logic             rx_wait_hi, rx_wait_hi_n;
    logic             rx_push;
    logic             ferr_n, perr_n;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt;
        rx_bit_n     = rx_bit;
        rx_shift_n   = rx_shift;
        rx_par_bad_n = rx_par_bad;
        rx_wait_hi_n = rx_wait_hi;
        rx_push      = 1'b0;
        ferr_n       = 1'b0;
        perr_n       = 1'b0;
        unique case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = '0;
                end
            end
            S_START: begin
                // Half a bit in: confirm the start bit, then every later
                // sample lands one full bit period later, i.e. mid-bit.
                if (rx_cnt == HALF_END) begin
                    rx_cnt_n     = '0;
                    rx_bit_n     = '0;
                    rx_par_bad_n = 1'b0;
                    rx_state_n   = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[DWL-1:1]};
                    if (rx_bit == LAST_BIT) begin
                        rx_state_n = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_STOP;
                    if (PAR_EN && (((^rx_shift) ^ rx_sync) != PAR_ODD)) begin
                        perr_n       = 1'b1;
                        rx_par_bad_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_wait_hi) begin
                    // After a framing error, stay here until the line is high.
                    if (rx_sync) begin
                        rx_wait_hi_n = 1'b0;
                        rx_state_n   = S_IDLE;
                    end
                end else if (rx_cnt == BIT_END) begin
                    rx_cnt_n = '0;
                    if (!rx_sync) begin
                        ferr_n       = 1'b1;
                        rx_wait_hi_n = 1'b1;
                    end else begin
                        rx_state_n = S_IDLE;
                        rx_push    = !rx_par_bad;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: begin
                rx_state_n   = S_IDLE;
                rx_cnt_n     = '0;
                rx_wait_hi_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
            rx_wait_hi <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            rx_par_bad <= rx_par_bad_n;
            rx_wait_hi <= rx_wait_hi_n;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FIFO (first-word-fall-through)
    // -----------------------------------------------------------------------
    logic [DWL-1:0] mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, do_push, ovr_n;
    logic             ovr_q, ferr_q, perr_q;

    assign full    = (count == FULL_CNT);
    assign rx_valid = (count != '0);
    assign pop     = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = rx_push && (!full || pop);
    assign ovr_n   = rx_push && full && !pop;
    assign rx_data = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !do_push) begin
                count <= count - 1'b1;
            end
            ovr_q  <= ovr_n;
            ferr_q <= ferr_n;
            perr_q <= perr_n;
        end
    end

    assign rx_overrun    = ovr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = PAR_EN & perr_q;
    assign dbg_state     = {tx_state, rx_state};

endmodule

// File: tb/tb_uart_core.sv
// ---------------------------------------------------------------------------
// tb_uart_core : self-checking bench for uart_core (DWL=8, CLK_DIV=16,
// one stop bit, 4-entry receive FIFO). Expected line levels come from the
// frame rule (start, data LSB first, optional parity, stop); expected
// received words come from a queue modelling a bounded FIFO.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_core;

    localparam int DWL   = 8;
    localparam int DIV   = 16;
    localparam int STOPS = 1;
    localparam int DEPTH = 4;
    localparam int PODD  = 0;
`ifdef UART_PARITY_EN
    localparam bit TB_PAR = 1'b1;
`else
    localparam bit TB_PAR = 1'b0;
`endif
    localparam int NBITS  = 1 + DWL + (TB_PAR ? 1 : 0) + STOPS;
    localparam int FRAME  = NBITS * DIV;
    localparam int BUDGET = 4 * FRAME;

    // ---------------- clock / reset / DUT ----------------
    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           rx_drv = 1'b1;
    logic           loop = 1'b0;
    logic           rx_line;
    logic           Tx;
    logic [DWL-1:0] tx_data = '0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [DWL-1:0] rx_data;
    logic           rx_valid;
    logic           rx_ready = 1'b0;
    logic           rx_overrun, rx_frame_err, rx_parity_err;
    logic [5:0]     dbg_state;

    always #5 CLK = ~CLK;

    assign rx_line = loop ? Tx : rx_drv;

    uart_core #(
        .DWL(DWL), .CLK_DIV(DIV), .STOP_BITS(STOPS),
        .RX_FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
    ) dut (
        .CLK(CLK), .RST(RST), .Rx(rx_line), .Tx(Tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [DWL-1:0] exp_q[$];
    int n_ovr = 0, n_ferr = 0, n_perr = 0;

    always @(negedge CLK) begin
        if (rx_overrun === 1'b1) n_ovr++;
        if (rx_frame_err === 1'b1) n_ferr++;
        if (rx_parity_err === 1'b1) n_perr++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic good_par(input logic [DWL-1:0] w);
        return (($countones(w) % 2) == 1) ^ (PODD != 0);
    endfunction

    // Line level of bit k of a frame carrying w.
    function automatic logic frame_bit(input logic [DWL-1:0] w, input int k,
                                       input logic par, input logic stop_lvl);
        if (k == 0) return 1'b0;
        if (k <= DWL) return w[k-1];
        if (TB_PAR && k == DWL + 1) return par;
        return stop_lvl;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_tx_ready(output logic ok);
        int n = 0;
        while (tx_ready !== 1'b1 && n < BUDGET) begin
            @(posedge CLK); #1; n++;
        end
        ok = (tx_ready === 1'b1);
    endtask

    task automatic drive_rx_frame(input logic [DWL-1:0] w, input logic par,
                                  input logic stop_lvl);
        for (int k = 0; k < NBITS; k++) begin
            rx_drv = frame_bit(w, k, par, stop_lvl);
            repeat (DIV) @(posedge CLK);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    task automatic pop_word(output logic v, output logic [DWL-1:0] d);
        v = rx_valid;
        d = rx_data;
        rx_ready = 1'b1;
        @(posedge CLK); #1;
        rx_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RST = 1'b0;
        #22;
        checks++;
        if (Tx !== 1'b1 || tx_ready !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0 ||
            rx_overrun !== 1'b0 || rx_frame_err !== 1'b0 || rx_parity_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got Tx=%b rdy=%b rv=%b rd=%h err=%b%b%b need 1 0 0 00 000",
                     Tx, tx_ready, rx_valid, rx_data, rx_overrun, rx_frame_err, rx_parity_err);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got %b need 0", tx_ready);
        end
        @(posedge CLK); #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_first_edge got %b need 1", tx_ready);
        end
    endtask

    task automatic test_tx_frame;
        logic [DWL-1:0] w;
        logic ok, e;
        for (int n = 0; n < 3; n++) begin
            w = (n == 0) ? 8'hA5 : DWL'($urandom_range(0, 255));
            wait_tx_ready(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL tx_ready_wait got 0 need 1");
            end
            tx_data = w;
            tx_valid = 1'b1;
            @(posedge CLK); #1;
            tx_valid = 1'b0;
            for (int k = 0; k < FRAME; k++) begin
                e = frame_bit(w, k / DIV, good_par(w), 1'b1);
                checks++;
                if (Tx !== e || tx_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_line w=%h cyc=%0d got Tx=%b rdy=%b need Tx=%b rdy=0",
                             w, k, Tx, tx_ready, e);
                end
                @(posedge CLK); #1;
            end
            checks++;
            if (tx_ready !== 1'b1 || Tx !== 1'b1) begin
                failures++;
                $display("FAIL tx_end w=%h got rdy=%b Tx=%b need 1 1", w, tx_ready, Tx);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [DWL-1:0] words [4];
        logic [DWL-1:0] d, e;
        logic v, hs;
        int sent, cyc, last, f0, o0, p0;
        words[0] = 8'h3C; words[1] = 8'hFF; words[2] = 8'h00;
        words[3] = DWL'($urandom_range(0, 255));
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        loop = 1'b1;
        tx_data = words[0];
        tx_valid = 1'b1;
        sent = 0; cyc = 0; last = 0;
        while (sent < 4 && cyc < 4 * BUDGET) begin
            hs = tx_ready;
            @(posedge CLK); #1; cyc++;
            if (hs) begin
                if (sent > 0) begin
                    checks++;
                    if (cyc - last != FRAME + 1) begin
                        failures++;
                        $display("FAIL b2b_interval got %0d need %0d", cyc - last, FRAME + 1);
                    end
                end
                last = cyc;
                exp_q.push_back(words[sent]);
                sent++;
                if (sent < 4) tx_data = words[sent];
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        checks++;
        if (sent != 4) begin
            failures++;
            $display("FAIL b2b_sent got %0d need 4", sent);
        end
        repeat (FRAME + 2 * DIV) @(posedge CLK);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(v, d);
            checks++;
            if (v !== 1'b1 || d !== e) begin
                failures++;
                $display("FAIL loop_word got v=%b d=%h need v=1 d=%h", v, d, e);
            end
        end
        checks++;
        if (n_ferr != f0 || n_ovr != o0 || n_perr != p0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL loop_errs got f=%0d o=%0d p=%0d rv=%b need 0 0 0 0",
                     n_ferr - f0, n_ovr - o0, n_perr - p0, rx_valid);
        end
        loop = 1'b0;
    endtask

    task automatic test_overrun;
        logic [DWL-1:0] w, d, e;
        logic v;
        int ovr_exp, o0;
        ovr_exp = 0;
        o0 = n_ovr;
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = DWL'($urandom_range(0, 255));
            drive_rx_frame(w, good_par(w), 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else ovr_exp++;
        end
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (n_ovr - o0 != ovr_exp) begin
            failures++;
            $display("FAIL overrun_pulses got %0d need %0d", n_ovr - o0, ovr_exp);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_word(v, d);
            checks++;
            if (v !== 1'b1 || d !== e) begin
                failures++;
                $display("FAIL ovr_drain got v=%b d=%h need v=1 d=%h", v, d, e);
            end
        end
        // Popping an empty FIFO must not disturb it.
        rx_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_pop got rv=%b need 0", rx_valid);
        end
        w = DWL'($urandom_range(0, 255));
        drive_rx_frame(w, good_par(w), 1'b1);
        #1;
        pop_word(v, d);
        checks++;
        if (v !== 1'b1 || d !== w) begin
            failures++;
            $display("FAIL after_empty_pop got v=%b d=%h need v=1 d=%h", v, d, w);
        end
    endtask

    task automatic test_false_start_frame_err;
        logic [DWL-1:0] w, d;
        logic v;
        int f0, o0;
        f0 = n_ferr; o0 = n_ovr;
        rx_drv = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        rx_drv = 1'b1;
        repeat (3 * DIV) @(posedge CLK);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || n_ferr != f0 || n_ovr != o0) begin
            failures++;
            $display("FAIL false_start got rv=%b ferr=%0d ovr=%0d need 0 0 0",
                     rx_valid, n_ferr - f0, n_ovr - o0);
        end
        w = DWL'($urandom_range(0, 255));
        drive_rx_frame(w, good_par(w), 1'b0);
        rx_drv = 1'b0;
        repeat (2 * DIV) @(posedge CLK);
        #1;
        rx_drv = 1'b1;
        repeat (DIV) @(posedge CLK);
        #1;
        checks++;
        if (n_ferr - f0 != 1 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_err got pulses=%0d rv=%b need 1 0", n_ferr - f0, rx_valid);
        end
        w = DWL'($urandom_range(0, 255));
        drive_rx_frame(w, good_par(w), 1'b1);
        #1;
        pop_word(v, d);
        checks++;
        if (v !== 1'b1 || d !== w) begin
            failures++;
            $display("FAIL after_frame_err got v=%b d=%h need v=1 d=%h", v, d, w);
        end
    endtask

    task automatic test_reset_midframe;
        logic [DWL-1:0] w, wt, d;
        logic v, ok;
        int f0, o0;
        // Leave one word in the FIFO so the reset has something to clear.
        w = DWL'($urandom_range(0, 255));
        drive_rx_frame(w, good_par(w), 1'b1);
        #1;
        checks++;
        if (rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_fill got rv=%b need 1", rx_valid);
        end
        wait_tx_ready(ok);
        wt = DWL'($urandom_range(0, 255)) & 8'hEF;
        w = DWL'($urandom_range(0, 255));
        fork
            begin
                tx_data = wt;
                tx_valid = 1'b1;
                @(posedge CLK); #1;
                tx_valid = 1'b0;
                drive_rx_frame(w, good_par(w), 1'b1);
            end
            begin
                // Middle of data bit 4 (frame bit 5) for both directions.
                repeat (1 + 5 * DIV + DIV / 2) @(posedge CLK);
                #2;
                RST = 1'b0;
                #1;
                checks++;
                if (Tx !== 1'b1 || tx_ready !== 1'b0 || rx_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL midframe_reset got Tx=%b rdy=%b rv=%b need 1 0 0",
                             Tx, tx_ready, rx_valid);
                end
            end
        join
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #3;
        f0 = n_ferr; o0 = n_ovr;
        RST = 1'b1;
        @(posedge CLK); #1;
        repeat (2 * FRAME) @(posedge CLK);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || n_ferr != f0 || n_ovr != o0 || Tx !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle got rv=%b ferr=%0d ovr=%0d Tx=%b need 0 0 0 1",
                     rx_valid, n_ferr - f0, n_ovr - o0, Tx);
        end
        loop = 1'b1;
        wait_tx_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL post_reset_ready got 0 need 1");
        end
        wt = DWL'($urandom_range(0, 255));
        tx_data = wt;
        tx_valid = 1'b1;
        @(posedge CLK); #1;
        tx_valid = 1'b0;
        repeat (FRAME + DIV) @(posedge CLK);
        #1;
        pop_word(v, d);
        checks++;
        if (v !== 1'b1 || d !== wt) begin
            failures++;
            $display("FAIL post_reset_frame got v=%b d=%h need v=1 d=%h", v, d, wt);
        end
        loop = 1'b0;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        logic [DWL-1:0] d;
        logic v;
        int p0;
        p0 = n_perr;
        drive_rx_frame(8'h01, ~good_par(8'h01), 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (n_perr - p0 != 1 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL parity_bad got pulses=%0d rv=%b need 1 0", n_perr - p0, rx_valid);
        end
        drive_rx_frame(8'h01, good_par(8'h01), 1'b1);
        #1;
        pop_word(v, d);
        checks++;
        if (v !== 1'b1 || d !== 8'h01 || n_perr - p0 != 1) begin
            failures++;
            $display("FAIL parity_good got v=%b d=%h pulses=%0d need 1 01 1",
                     v, d, n_perr - p0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_overrun();
        test_false_start_frame_err();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
